// File: rtl/sap_control_sequencer.sv
// Micro-step sequencer and control-word decoder for the SAP-U bus computer.
// Optional single-step button support is enabled with `define SAP_SINGLE_STEP_EN.
module sap_control_sequencer #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    input  logic       prog_mode,
`ifdef SAP_SINGLE_STEP_EN
    input  logic       single_step,
    input  logic       step_btn,
`endif
    output logic [2:0] step,
    output logic       hlt,
    output logic       mar_load_n,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       pc_enable,
    output logic       pc_out,
    output logic       pc_jump
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic mar_load;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
        logic pc_enable;
        logic pc_out;
        logic pc_jump;
        logic set_halt;
    } ctrl_t;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic [2:0] last_step;
    logic [2:0] end_step;
    logic       advance;
    ctrl_t      raw, ctrl;

`ifdef SAP_SINGLE_STEP_EN
    logic [1:0] btn_sync_q, btn_sync_d;
    logic       btn_prev_q, btn_prev_d;
    logic       adv_pulse;

    assign btn_sync_d = {btn_sync_q[0], step_btn};
    assign btn_prev_d = btn_sync_q[1];
    assign adv_pulse  = btn_sync_q[1] & ~btn_prev_q;
    assign advance    = ~single_step | adv_pulse;
`else
    assign advance    = 1'b1;
`endif

    always_comb begin
        raw = '0;
        case (step_q)
            3'd0: begin
                raw.pc_out   = 1'b1;
                raw.mar_load = 1'b1;
            end
            3'd1: begin
                raw.ram_out   = 1'b1;
                raw.ir_in     = 1'b1;
                raw.pc_enable = 1'b1;
            end
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        raw.ir_out   = 1'b1;
                        raw.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        raw.ir_out = 1'b1;
                        raw.a_in   = 1'b1;
                    end
                    OP_JMP: begin
                        raw.ir_out  = 1'b1;
                        raw.pc_jump = 1'b1;
                    end
                    OP_JC: begin
                        raw.ir_out  = carry_flag;
                        raw.pc_jump = carry_flag;
                    end
                    OP_JZ: begin
                        raw.ir_out  = zero_flag;
                        raw.pc_jump = zero_flag;
                    end
                    OP_OUT: begin
                        raw.a_out  = 1'b1;
                        raw.out_in = 1'b1;
                    end
                    OP_HLT:  raw.set_halt = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: begin
                        raw.ram_out = 1'b1;
                        raw.a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        raw.ram_out = 1'b1;
                        raw.b_in    = 1'b1;
                    end
                    OP_STA: begin
                        raw.a_out  = 1'b1;
                        raw.ram_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    raw.alu_out  = 1'b1;
                    raw.a_in     = 1'b1;
                    raw.flags_in = 1'b1;
                    raw.alu_sub  = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // Last step that does anything for the current opcode; untaken jumps end after fetch.
    always_comb begin
        last_step = 3'd1;
        case (opcode)
            OP_LDA, OP_STA:                 last_step = 3'd3;
            OP_ADD, OP_SUB:                 last_step = 3'd4;
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step = 3'd2;
            OP_JC:   last_step = carry_flag ? 3'd2 : 3'd1;
            OP_JZ:   last_step = zero_flag  ? 3'd2 : 3'd1;
            default: last_step = 3'd1;
        endcase
    end

    assign end_step = EARLY_END ? last_step : 3'(NUM_STEPS - 1);

    always_comb begin
        ctrl = raw;
`ifdef SAP_SINGLE_STEP_EN
        if (single_step && !adv_pulse) begin
            ctrl.mar_load  = 1'b0;
            ctrl.ram_in    = 1'b0;
            ctrl.ir_in     = 1'b0;
            ctrl.a_in      = 1'b0;
            ctrl.b_in      = 1'b0;
            ctrl.flags_in  = 1'b0;
            ctrl.out_in    = 1'b0;
            ctrl.pc_enable = 1'b0;
            ctrl.pc_jump   = 1'b0;
            ctrl.set_halt  = 1'b0;
        end
`endif
        if (prog_mode || halted_q) begin
            ctrl = '0;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (prog_mode) begin
            step_d = 3'd0;
        end else if (!halted_q && advance) begin
            halted_d = ctrl.set_halt;
            step_d   = (step_q >= end_step) ? 3'd0 : step_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
`ifdef SAP_SINGLE_STEP_EN
            btn_sync_q <= 2'b00;
            btn_prev_q <= 1'b0;
`endif
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
`ifdef SAP_SINGLE_STEP_EN
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
`endif
        end
    end

    assign step       = step_q;
    assign hlt        = halted_q;
    assign mar_load_n = ~ctrl.mar_load;
    assign ram_in     = ctrl.ram_in;
    assign ram_out    = ctrl.ram_out;
    assign ir_in      = ctrl.ir_in;
    assign ir_out     = ctrl.ir_out;
    assign a_in       = ctrl.a_in;
    assign a_out      = ctrl.a_out;
    assign b_in       = ctrl.b_in;
    assign alu_out    = ctrl.alu_out;
    assign alu_sub    = ctrl.alu_sub;
    assign flags_in   = ctrl.flags_in;
    assign out_in     = ctrl.out_in;
    assign pc_enable  = ctrl.pc_enable;
    assign pc_out     = ctrl.pc_out;
    assign pc_jump    = ctrl.pc_jump;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: directed vector table, hand-written corner
// sequences, and a randomized run against a micro-program table model.
module tb_sap_control_sequencer;

    localparam int NUM_STEPS = 5;
    localparam bit EARLY_END = 1'b1;

    localparam logic [15:0] C_MAR     = 16'h0001;
    localparam logic [15:0] C_RAM_IN  = 16'h0002;
    localparam logic [15:0] C_RAM_OUT = 16'h0004;
    localparam logic [15:0] C_IR_IN   = 16'h0008;
    localparam logic [15:0] C_IR_OUT  = 16'h0010;
    localparam logic [15:0] C_A_IN    = 16'h0020;
    localparam logic [15:0] C_A_OUT   = 16'h0040;
    localparam logic [15:0] C_B_IN    = 16'h0080;
    localparam logic [15:0] C_ALU_OUT = 16'h0100;
    localparam logic [15:0] C_ALU_SUB = 16'h0200;
    localparam logic [15:0] C_FLAGS   = 16'h0400;
    localparam logic [15:0] C_OUT_IN  = 16'h0800;
    localparam logic [15:0] C_PC_EN   = 16'h1000;
    localparam logic [15:0] C_PC_OUT  = 16'h2000;
    localparam logic [15:0] C_PC_JUMP = 16'h4000;
    localparam logic [15:0] C_HALT    = 16'h8000;
    localparam logic [15:0] F0 = C_PC_OUT | C_MAR;
    localparam logic [15:0] F1 = C_RAM_OUT | C_IR_IN | C_PC_EN;

    logic       clk;
    logic       clear;
    logic [3:0] opcode;
    logic       carry_flag, zero_flag, prog_mode;
    logic [2:0] step;
    logic       hlt, mar_load_n, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in;
    logic       alu_out, alu_sub, flags_in, out_in, pc_enable, pc_out, pc_jump;
`ifdef SAP_SINGLE_STEP_EN
    logic       single_step, step_btn;
`endif

    sap_control_sequencer #(.NUM_STEPS(NUM_STEPS), .EARLY_END(EARLY_END)) dut (
        .clk(clk), .clear(clear), .opcode(opcode), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .prog_mode(prog_mode),
`ifdef SAP_SINGLE_STEP_EN
        .single_step(single_step), .step_btn(step_btn),
`endif
        .step(step), .hlt(hlt), .mar_load_n(mar_load_n), .ram_in(ram_in),
        .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in),
        .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub),
        .flags_in(flags_in), .out_in(out_in), .pc_enable(pc_enable),
        .pc_out(pc_out), .pc_jump(pc_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dut_w;
    logic [4:0]  bus_w;
    assign dut_w = {1'b0, pc_jump, pc_out, pc_enable, out_in, flags_in, alu_sub, alu_out,
                    b_in, a_out, a_in, ir_out, ir_in, ram_out, ram_in, ~mar_load_n};
    assign bus_w = {pc_out, ram_out, ir_out, a_out, alu_out};

    int checks = 0;
    int errors = 0;

    // Execute-phase micro-program per opcode, steps 2..4.
    logic [15:0] exec_tbl [16][3];

    int m_step;
    bit m_halted;

    typedef struct {
        logic        clr;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic        pm;
        logic [2:0]  st;
        logic [15:0] w;
        logic        h;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [3:0] op, input logic c,
                                             input logic z, input int s);
        logic [15:0] w;
        w = '0;
        if (s == 0) w = F0;
        else if (s == 1) w = F1;
        else if (s <= 4) begin
            w = exec_tbl[op][s-2];
            if ((op == 4'd7 && !c) || (op == 4'd8 && !z)) w = '0;
        end
        return w;
    endfunction

    function automatic int ref_last(input logic [3:0] op, input logic c, input logic z);
        int last;
        last = 0;
        for (int i = 0; i < NUM_STEPS; i++)
            if (ref_word(op, c, z, i) != 16'h0) last = i;
        return EARLY_END ? last : NUM_STEPS - 1;
    endfunction

    task automatic model_edge();
        logic [15:0] w;
        if (clear) begin
            m_step = 0;
            m_halted = 1'b0;
        end else if (prog_mode) begin
            m_step = 0;
        end else if (!m_halted) begin
            w = ref_word(opcode, carry_flag, zero_flag, m_step);
            if ((w & C_HALT) != 16'h0) m_halted = 1'b1;
            m_step = (m_step >= ref_last(opcode, carry_flag, zero_flag)) ? 0 : m_step + 1;
        end
    endtask

    task automatic add_vec(input logic clr, input logic [3:0] op, input logic c,
                           input logic z, input logic pm, input logic [2:0] st,
                           input logic [15:0] w, input logic h);
        vec_t v;
        v.clr = clr; v.op = op; v.c = c; v.z = z; v.pm = pm; v.st = st; v.w = w; v.h = h;
        vecs.push_back(v);
    endtask

    task automatic apply_and_check(input string name, input logic clr, input logic [3:0] op,
                                   input logic c, input logic z, input logic pm,
                                   input logic [2:0] st, input logic [15:0] w, input logic h);
        @(negedge clk);
        clear = clr; opcode = op; carry_flag = c; zero_flag = z; prog_mode = pm;
        #1;
        check({name, "_step"}, 32'(step), 32'(st));
        check({name, "_ctrl"}, 32'(dut_w), 32'(w));
        check({name, "_hlt"}, 32'(hlt), 32'(h));
    endtask

    initial begin
        clear = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0; prog_mode = 1'b0;
`ifdef SAP_SINGLE_STEP_EN
        single_step = 1'b0; step_btn = 1'b0;
`endif
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 3; s++) exec_tbl[o][s] = '0;
        exec_tbl[1][0]  = C_IR_OUT | C_MAR;  exec_tbl[1][1] = C_RAM_OUT | C_A_IN;
        exec_tbl[2][0]  = C_IR_OUT | C_MAR;  exec_tbl[2][1] = C_RAM_OUT | C_B_IN;
        exec_tbl[2][2]  = C_ALU_OUT | C_A_IN | C_FLAGS;
        exec_tbl[3][0]  = C_IR_OUT | C_MAR;  exec_tbl[3][1] = C_RAM_OUT | C_B_IN;
        exec_tbl[3][2]  = C_ALU_OUT | C_A_IN | C_FLAGS | C_ALU_SUB;
        exec_tbl[4][0]  = C_IR_OUT | C_MAR;  exec_tbl[4][1] = C_A_OUT | C_RAM_IN;
        exec_tbl[5][0]  = C_IR_OUT | C_A_IN;
        exec_tbl[6][0]  = C_IR_OUT | C_PC_JUMP;
        exec_tbl[7][0]  = C_IR_OUT | C_PC_JUMP;
        exec_tbl[8][0]  = C_IR_OUT | C_PC_JUMP;
        exec_tbl[14][0] = C_A_OUT | C_OUT_IN;
        exec_tbl[15][0] = C_HALT;

        add_vec(1, 4'h1, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h1, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h1, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h1, 0, 0, 0, 2, C_IR_OUT | C_MAR, 0);
        add_vec(0, 4'h1, 0, 0, 0, 3, C_RAM_OUT | C_A_IN, 0);
        add_vec(0, 4'h3, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h3, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h3, 0, 0, 0, 2, C_IR_OUT | C_MAR, 0);
        add_vec(0, 4'h3, 0, 0, 0, 3, C_RAM_OUT | C_B_IN, 0);
        add_vec(0, 4'h3, 0, 0, 0, 4, C_ALU_OUT | C_A_IN | C_FLAGS | C_ALU_SUB, 0);
        add_vec(0, 4'h7, 1, 0, 0, 0, F0, 0);
        add_vec(0, 4'h7, 1, 0, 0, 1, F1, 0);
        add_vec(0, 4'h7, 1, 0, 0, 2, C_IR_OUT | C_PC_JUMP, 0);
        add_vec(0, 4'h7, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h7, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h5, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h5, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h5, 0, 0, 0, 2, C_IR_OUT | C_A_IN, 0);
        add_vec(0, 4'h0, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h0, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'hE, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'hE, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'hE, 0, 0, 0, 2, C_A_OUT | C_OUT_IN, 0);
        add_vec(0, 4'h4, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h4, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h4, 0, 0, 0, 2, C_IR_OUT | C_MAR, 0);
        add_vec(0, 4'h4, 0, 0, 0, 3, C_A_OUT | C_RAM_IN, 0);
        add_vec(0, 4'h8, 0, 1, 0, 0, F0, 0);
        add_vec(0, 4'h8, 0, 1, 0, 1, F1, 0);
        add_vec(0, 4'h8, 0, 1, 0, 2, C_IR_OUT | C_PC_JUMP, 0);
        add_vec(0, 4'h6, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h6, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h6, 0, 0, 0, 2, C_IR_OUT | C_PC_JUMP, 0);
        add_vec(0, 4'h9, 0, 0, 0, 0, F0, 0);
        add_vec(0, 4'h9, 0, 0, 0, 1, F1, 0);
        add_vec(0, 4'h9, 0, 0, 0, 0, F0, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply_and_check($sformatf("vec%0d", i), vecs[i].clr, vecs[i].op, vecs[i].c,
                            vecs[i].z, vecs[i].pm, vecs[i].st, vecs[i].w, vecs[i].h);

        // Halt: freezes, then only clear releases it.
        apply_and_check("hlt_clr", 1, 4'hF, 0, 0, 0, 0, F0, 0);
        apply_and_check("hlt_s0", 0, 4'hF, 0, 0, 0, 0, F0, 0);
        apply_and_check("hlt_s1", 0, 4'hF, 0, 0, 0, 1, F1, 0);
        apply_and_check("hlt_s2", 0, 4'hF, 0, 0, 0, 2, 16'h0, 0);
        for (int i = 0; i < 10; i++)
            apply_and_check("halted", 0, 4'h1, 0, 0, 0, 0, 16'h0, 1);
        @(posedge clk);
        #2 clear = 1'b1;
        #1;
        check("midclr_step", 32'(step), 32'd0);
        check("midclr_hlt", 32'(hlt), 32'd0);
        check("midclr_ctrl", 32'(dut_w), 32'(F0));

        // prog_mode aborts an ADD at s3.
        apply_and_check("pm_clr", 1, 4'h2, 0, 0, 0, 0, F0, 0);
        apply_and_check("pm_s0", 0, 4'h2, 0, 0, 0, 0, F0, 0);
        apply_and_check("pm_s1", 0, 4'h2, 0, 0, 0, 1, F1, 0);
        apply_and_check("pm_s2", 0, 4'h2, 0, 0, 0, 2, C_IR_OUT | C_MAR, 0);
        apply_and_check("pm_at_s3", 0, 4'h2, 0, 0, 1, 3, 16'h0, 0);
        apply_and_check("pm_abort", 0, 4'h2, 0, 0, 1, 0, 16'h0, 0);
        check("pm_mar_n", 32'(mar_load_n), 32'd1);
        apply_and_check("pm_hold", 0, 4'h2, 0, 0, 1, 0, 16'h0, 0);
        apply_and_check("pm_rel_s0", 0, 4'h2, 0, 0, 0, 0, F0, 0);
        apply_and_check("pm_rel_s1", 0, 4'h2, 0, 0, 0, 1, F1, 0);

        // Randomized run against the micro-program model.
        apply_and_check("rand_clr", 1, 4'h0, 0, 0, 0, 0, F0, 0);
        m_step = 0;
        m_halted = 1'b0;
        @(posedge clk);
        model_edge();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [15:0] exp_w;
            @(negedge clk);
            if (m_step == 0) begin
                opcode     = 4'($urandom);
                carry_flag = 1'($urandom);
                zero_flag  = 1'($urandom);
            end
            prog_mode = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 49) == 0);
            if (clear) begin
                m_step = 0;
                m_halted = 1'b0;
            end
            #1;
            exp_w = (prog_mode || m_halted) ? 16'h0
                    : (ref_word(opcode, carry_flag, zero_flag, m_step) & ~C_HALT);
            check("rand_step", 32'(step), 32'(m_step));
            check("rand_ctrl", 32'(dut_w), 32'(exp_w));
            check("rand_hlt", 32'(hlt), 32'(m_halted));
            check("bus_single_driver", 32'($countones(bus_w) <= 1), 32'd1);
            if (prog_mode) check("prog_mar_idle", 32'(mar_load_n), 32'd1);
            @(posedge clk);
            model_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
